// File: rtl/ndchannel_if.sv
// ndchannel_if: paired input/output valid-ready channel of ndchannel
interface ndchannel_if #(parameter int DATA_TYPE = 32) ();
  logic [DATA_TYPE-1:0] ins, outs;
  logic ins_valid, ins_ready, outs_valid, outs_ready;
  modport slave (input ins, ins_valid, outs_ready, output ins_ready, outs, outs_valid);
  modport master (output ins, ins_valid, outs_ready, input ins_ready, outs, outs_valid);
endinterface

// File: rtl/ndchannel.sv
// ndchannel: circular FIFO channel with LFSR-driven random stalls; NDCHANNEL_STALL_CNT_EN adds stall_cnt
module ndchannel #(
  parameter int DATA_TYPE = 32,
  parameter int DEPTH = 4,
  parameter int MODE = 3,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input logic clk,
  input logic rst,
  ndchannel_if.slave ch
`ifdef NDCHANNEL_STALL_CNT_EN
  , output logic [15:0] stall_cnt
`endif
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [15:0] S0 = SEED == 16'h0000 ? 16'h0001 : SEED;
  logic [DATA_TYPE-1:0] mem [DEPTH];
  logic [AW-1:0] rptr, wptr;
  logic [CW-1:0] count;
  logic [15:0] lfsr;
  logic hold, in_stall, out_stall, push, pop;
  always_comb begin
    in_stall = (MODE == 1 || MODE == 3) ? lfsr[0] : 1'b0;
    out_stall = (MODE == 2 || MODE == 3) ? lfsr[1] : 1'b0;
    ch.ins_ready = !rst && count < CW'(DEPTH) && !in_stall;
    ch.outs_valid = !rst && count != '0 && (hold || !out_stall);
    ch.outs = mem[rptr];
    push = ch.ins_valid && ch.ins_ready;
    pop = ch.outs_valid && ch.outs_ready;
  end
  // hold keeps an offered word on the output until it is taken, masking out_stall
  always_ff @(posedge clk) begin
    if (rst) begin
      rptr <= '0;
      wptr <= '0;
      count <= '0;
      hold <= 1'b0;
      lfsr <= S0;
    end else begin
      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      if (push) wptr <= wptr == AW'(DEPTH - 1) ? '0 : wptr + 1'b1;
      if (pop) rptr <= rptr == AW'(DEPTH - 1) ? '0 : rptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      hold <= ch.outs_valid && !ch.outs_ready;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= ch.ins;
  end
`ifdef NDCHANNEL_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) stall_cnt <= '0;
    else if (((ch.ins_valid && !ch.ins_ready) || (count != '0 && !ch.outs_valid)) && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 1'b1;
  end
`endif
endmodule

// File: tb/tb_ndchannel.sv
// tb_ndchannel: four ndchannel configurations on shared stimulus, checked against a queue model
module tb_ndchannel;
  logic clk = 0, rst = 1, vin = 0, ordy = 0;
  logic [31:0] din = 0;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  ndchannel_if #(.DATA_TYPE(32)) if0 (), if1 (), if2 (), if3 ();
  assign if0.ins = din;
  assign if0.ins_valid = vin;
  assign if0.outs_ready = ordy;
  assign if1.ins = din;
  assign if1.ins_valid = vin;
  assign if1.outs_ready = ordy;
  assign if2.ins = din;
  assign if2.ins_valid = vin;
  assign if2.outs_ready = ordy;
  assign if3.ins = din;
  assign if3.ins_valid = vin;
  assign if3.outs_ready = ordy;
  logic ardy [4], avld [4];
  logic [31:0] aout [4];
  logic [15:0] acnt [4];
  assign ardy[0] = if0.ins_ready;
  assign ardy[1] = if1.ins_ready;
  assign ardy[2] = if2.ins_ready;
  assign ardy[3] = if3.ins_ready;
  assign avld[0] = if0.outs_valid;
  assign avld[1] = if1.outs_valid;
  assign avld[2] = if2.outs_valid;
  assign avld[3] = if3.outs_valid;
  assign aout[0] = if0.outs;
  assign aout[1] = if1.outs;
  assign aout[2] = if2.outs;
  assign aout[3] = if3.outs;
  ndchannel #(.DATA_TYPE(32), .DEPTH(4), .MODE(0)) u0 (.clk(clk), .rst(rst), .ch(if0)
`ifdef NDCHANNEL_STALL_CNT_EN
    , .stall_cnt(acnt[0])
`endif
  );
  ndchannel #(.DATA_TYPE(32), .DEPTH(2), .MODE(0)) u1 (.clk(clk), .rst(rst), .ch(if1)
`ifdef NDCHANNEL_STALL_CNT_EN
    , .stall_cnt(acnt[1])
`endif
  );
  ndchannel #(.DATA_TYPE(32), .DEPTH(4), .MODE(2), .SEED(16'hACE1)) u2 (.clk(clk), .rst(rst), .ch(if2)
`ifdef NDCHANNEL_STALL_CNT_EN
    , .stall_cnt(acnt[2])
`endif
  );
  ndchannel #(.DATA_TYPE(32), .DEPTH(3), .MODE(3), .SEED(16'h0000)) u3 (.clk(clk), .rst(rst), .ch(if3)
`ifdef NDCHANNEL_STALL_CNT_EN
    , .stall_cnt(acnt[3])
`endif
  );
`ifndef NDCHANNEL_STALL_CNT_EN
  assign acnt[0] = 16'h0;
  assign acnt[1] = 16'h0;
  assign acnt[2] = 16'h0;
  assign acnt[3] = 16'h0;
`endif
  int dep [4] = '{4, 2, 4, 3};
  int mode [4] = '{0, 0, 2, 3};
  logic [15:0] seed [4] = '{16'hACE1, 16'hACE1, 16'hACE1, 16'h0001};
  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h want %h at %0t", nm, k, act, exp, $time);
    end
  endtask
  function automatic logic [15:0] step(input logic [15:0] l);
    return (l >> 1) | (16'((l ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 16'd1) << 15);
  endfunction
  logic [31:0] mq [4][64];
  int hd [4], sz [4];
  logic hold [4];
  logic [15:0] lf [4], sc [4];
  initial begin
    logic er, ev, ist, ost;
    for (int k = 0; k < 4; k++) begin
      hd[k] = 0;
      sz[k] = 0;
      hold[k] = 0;
      lf[k] = seed[k];
      sc[k] = 0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        ist = (mode[k] == 1 || mode[k] == 3) && lf[k][0];
        ost = (mode[k] == 2 || mode[k] == 3) && lf[k][1];
        er = !rst && sz[k] < dep[k] && !ist;
        ev = !rst && sz[k] > 0 && (hold[k] || !ost);
        chk("ins_ready", k, 32'(ardy[k]), 32'(er));
        chk("outs_valid", k, 32'(avld[k]), 32'(ev));
        if (ev) chk("outs", k, aout[k], mq[k][hd[k]]);
`ifdef NDCHANNEL_STALL_CNT_EN
        chk("stall_cnt", k, 32'(acnt[k]), 32'(sc[k]));
`endif
        if (rst) begin
          hd[k] = 0;
          sz[k] = 0;
          hold[k] = 0;
          lf[k] = seed[k];
          sc[k] = 0;
        end else begin
          if (((vin && !er) || (sz[k] > 0 && !ev)) && sc[k] != 16'hFFFF) sc[k] = sc[k] + 16'd1;
          hold[k] = ev && !ordy;
          if (ev && ordy) begin
            hd[k] = (hd[k] + 1) % 64;
            sz[k]--;
          end
          if (vin && er) begin
            mq[k][(hd[k] + sz[k]) % 64] = din;
            sz[k]++;
          end
          lf[k] = step(lf[k]);
        end
      end
    end
  end
  task automatic cyc(input logic r, input logic v, input logic [31:0] d, input logic o);
    @(posedge clk);
    #1;
    rst = r;
    vin = v;
    din = d;
    ordy = o;
    @(negedge clk);
  endtask
  initial begin
    chk("lfsr_pin", 0, 32'(step(16'hACE1)), 32'h5670);
    chk("lfsr_pin", 1, 32'(step(16'h5670)), 32'hAB38);
    chk("lfsr_pin", 2, 32'(step(16'h0001)), 32'h8000);
    cyc(1, 0, 0, 0);
    chk("rst_valid", 0, 32'(avld[0]), 0);
    chk("rst_ready", 0, 32'(ardy[0]), 0);
    for (int i = 0; i < 11; i++) begin
      cyc(0, 1, 32'h100 + i, i == 10);
      if (i == 0) chk("first_ready", 0, 32'(ardy[0]), 1);
      if (i == 0) chk("first_valid", 0, 32'(avld[0]), 0);
      if (i == 9) chk("full_ready", 0, 32'(ardy[0]), 0);
      if (i == 10) begin
        chk("pop_ready", 0, 32'(ardy[0]), 0);
        chk("pop_outs", 0, aout[0], 32'h100);
`ifdef NDCHANNEL_STALL_CNT_EN
        chk("stall_cnt_lit", 1, 32'(acnt[1]), 8);
`endif
      end
    end
    cyc(0, 1, 32'h10B, 1);
    chk("refill_ready", 0, 32'(ardy[0]), 1);
    chk("refill_outs", 0, aout[0], 32'h101);
    cyc(1, 0, 0, 1);
    for (int i = 1; i <= 9; i++) begin
      cyc(0, i <= 8, i, 1);
      chk("seq_valid", 0, 32'(avld[0]), 32'(i > 1));
      if (i > 1) chk("seq_outs", 0, aout[0], i - 1);
    end
    for (int n = 0; n < 3000; n++)
      cyc(($urandom % 400) == 0, ($urandom % 4) != 0, $urandom, ($urandom % 3) != 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
